// File: rtl/iob_axistream_out_pkt.sv
// CPU-to-AXI-Stream bridge with packet trimming.
// The CPU pushes 32-bit words into a word FIFO. The unpacker serialises each word
// into TDATA_W-wide beats, sending the least significant lane first.
// The CPU can mark the next word as the last word of a packet and choose how many
// of its lanes to send. The block also provides an enable gate, a soft reset, a
// sticky overflow flag and a sent-packet counter.
module iob_axistream_out_pkt #(
    parameter int TDATA_W         = 8,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 5
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               iob_avalid,
    input  logic [ADDR_W-1:0]  iob_addr,
    input  logic [DATA_W-1:0]  iob_wdata,
    input  logic [3:0]         iob_wstrb,
    output logic               iob_rvalid,
    output logic [DATA_W-1:0]  iob_rdata,
    output logic               iob_ready,
    output logic [TDATA_W-1:0] tdata,
    output logic               tvalid,
    input  logic               tready,
    output logic               tlast
);

    localparam int R       = 32 / TDATA_W;
    localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam int LVL_W   = FIFO_DEPTH_LOG2 + 1;
    localparam int ENTRY_W = DATA_W + 4;

    localparam logic [2:0]        R_L      = 3'(R);
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
    localparam logic [ADDR_W-1:0] A_DATA   = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_LAST   = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] A_PKT    = ADDR_W'(32'h10);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // A lane count of 0, or one larger than the lanes in a word, means a full word.
    function automatic logic [2:0] clamp_lanes(input logic [2:0] n);
        if ((n == 3'd0) || (n > R_L)) begin
            return R_L;
        end else begin
            return n;
        end
    endfunction

    // CPU bus decode
    logic wr_s, rd_s, wr_data_s, wr_last_s, wr_ctrl_s, wr_status_s, srst_s;

    assign iob_ready   = 1'b1;
    assign wr_s        = iob_avalid & (|iob_wstrb);
    assign rd_s        = iob_avalid & ~(|iob_wstrb);
    assign wr_data_s   = wr_s & (iob_addr == A_DATA);
    assign wr_last_s   = wr_s & (iob_addr == A_LAST);
    assign wr_ctrl_s   = wr_s & (iob_addr == A_CTRL);
    assign wr_status_s = wr_s & (iob_addr == A_STATUS);
    assign srst_s      = wr_ctrl_s & iob_wdata[1];

    // Control and status registers
    logic        en_r, ovf_r, last_pend_r;
    logic [2:0]  last_nl_r;
    logic [15:0] pkt_cnt_r;

    // FIFO storage and occupancy
    logic [ENTRY_W-1:0]         mem_r [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0]           level_r;
    logic                       full_s, fifo_empty_s, push_s, pop_s, ovf_evt_s;
    logic [ENTRY_W-1:0]         head_s, entry_s;
    logic [DATA_W-1:0]          head_word_s;
    logic [2:0]                 head_nl_s;
    logic                       head_last_s;

    assign full_s       = (level_r == LVL_FULL);
    assign fifo_empty_s = (level_r == {LVL_W{1'b0}});
    assign head_s       = mem_r[rd_ptr_r];
    assign head_word_s  = head_s[DATA_W-1:0];
    assign head_nl_s    = head_s[DATA_W+:3];
    assign head_last_s  = head_s[DATA_W+3];
    assign entry_s      = {last_pend_r, (last_pend_r ? last_nl_r : R_L), iob_wdata};
    // A full FIFO still accepts a word when the unpacker pops in the same cycle.
    assign push_s       = wr_data_s & (~full_s | pop_s);
    assign ovf_evt_s    = wr_data_s & full_s & ~pop_s;

    // Unpacker state
    state_t      state_r, state_n;
    logic [31:0] word_r, word_n;
    logic [2:0]  lane_r, lane_n, nl_r, nl_n, word_end_s;
    logic        last_r, last_n, tlast_r, tlast_n, tvalid_r, tvalid_n, hs_s, at_end_s;

    // The current beat is always the low lane of word_r, so tdata comes straight from a flop.
    assign tdata      = word_r[TDATA_W-1:0];
    assign tvalid     = tvalid_r;
    assign tlast      = tlast_r;
    assign hs_s       = tvalid_r & tready;
    assign word_end_s = last_r ? (nl_r - 3'd1) : (R_L - 3'd1);
    assign at_end_s   = (lane_r == word_end_s);

    // Unpacker next state: load from the FIFO, shift to the next lane, or go idle
    always_comb begin
        state_n  = state_r;
        word_n   = word_r;
        lane_n   = lane_r;
        last_n   = last_r;
        nl_n     = nl_r;
        tlast_n  = tlast_r;
        tvalid_n = tvalid_r;
        pop_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && en_r) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_SEND: begin
                if (hs_s && at_end_s) begin
                    // Chain straight into the next word with no idle cycle when allowed.
                    if (!fifo_empty_s && en_r) begin
                        pop_s = 1'b1;
                    end else begin
                        state_n  = ST_IDLE;
                        tvalid_n = 1'b0;
                        tlast_n  = 1'b0;
                    end
                end else if (hs_s) begin
                    word_n  = word_r >> TDATA_W;
                    lane_n  = lane_r + 3'd1;
                    tlast_n = last_r && ((lane_r + 3'd1) == (nl_r - 3'd1));
                end else begin
                    state_n = state_r;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                tvalid_n = 1'b0;
                tlast_n  = 1'b0;
            end
        endcase
        if (pop_s) begin
            state_n  = ST_SEND;
            word_n   = head_word_s;
            lane_n   = 3'd0;
            last_n   = head_last_s;
            nl_n     = head_nl_s;
            tlast_n  = head_last_s && (head_nl_s == 3'd1);
            tvalid_n = 1'b1;
        end else begin
            lane_n = lane_n;
        end
        // A soft reset drops the beat immediately, even if it is stalled.
        if (srst_s) begin
            pop_s    = 1'b0;
            state_n  = ST_IDLE;
            word_n   = 32'h0;
            lane_n   = 3'd0;
            last_n   = 1'b0;
            nl_n     = 3'd0;
            tlast_n  = 1'b0;
            tvalid_n = 1'b0;
        end else begin
            nl_n = nl_n;
        end
    end

    // Unpacker registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r  <= ST_IDLE;
            word_r   <= 32'h0;
            lane_r   <= 3'd0;
            last_r   <= 1'b0;
            nl_r     <= 3'd0;
            tlast_r  <= 1'b0;
            tvalid_r <= 1'b0;
        end else begin
            state_r  <= state_n;
            word_r   <= word_n;
            lane_r   <= lane_n;
            last_r   <= last_n;
            nl_r     <= nl_n;
            tlast_r  <= tlast_n;
            tvalid_r <= tvalid_n;
        end
    end

    // FIFO payload storage; it needs no reset because level_r guards every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // FIFO pointers, level and LAST pending flag; all are flushed by a soft reset
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            last_pend_r <= 1'b0;
            last_nl_r   <= 3'd0;
        end else if (srst_s) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            last_pend_r <= 1'b0;
            last_nl_r   <= 3'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + 1'b1;
                2'b01:   level_r <= level_r - 1'b1;
                default: level_r <= level_r;
            endcase
            // A dropped word leaves the pending flag set for the next accepted word.
            if (wr_last_s) begin
                last_pend_r <= 1'b1;
                last_nl_r   <= clamp_lanes(iob_wdata[2:0]);
            end else if (push_s) begin
                last_pend_r <= 1'b0;
            end
        end
    end

    // Enable, overflow flag and packet counter; a soft reset leaves these unchanged
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            en_r      <= 1'b1;
            ovf_r     <= 1'b0;
            pkt_cnt_r <= 16'h0;
        end else begin
            if (wr_ctrl_s) begin
                en_r <= iob_wdata[0];
            end
            if (ovf_evt_s) begin
                ovf_r <= 1'b1;
            end else if (wr_status_s && iob_wdata[2]) begin
                ovf_r <= 1'b0;
            end
            if (hs_s && tlast_r) begin
                pkt_cnt_r <= pkt_cnt_r + 16'd1;
            end
        end
    end

    // Read data mux
    logic [DATA_W-1:0] rd_mux_s;

    // Select the read data for the requested register; unmapped addresses read as zero
    always_comb begin
        rd_mux_s = '0;
        case (iob_addr)
            A_CTRL: begin
                rd_mux_s[0] = en_r;
            end
            A_STATUS: begin
                rd_mux_s[0]          = full_s;
                rd_mux_s[1]          = fifo_empty_s & (state_r == ST_IDLE);
                rd_mux_s[2]          = ovf_r;
                rd_mux_s[16+:LVL_W]  = level_r;
            end
            A_PKT: begin
                rd_mux_s[15:0] = pkt_cnt_r;
            end
            default: begin
                rd_mux_s = '0;
            end
        endcase
    end

    // Read data is returned one cycle after the request
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            iob_rvalid <= 1'b0;
            iob_rdata  <= '0;
        end else begin
            iob_rvalid <= rd_s;
            iob_rdata  <= rd_s ? rd_mux_s : '0;
        end
    end

endmodule

// File: tb/tb_iob_axistream_out_pkt.sv
// Directed bench for iob_axistream_out_pkt (8-bit lanes, 4-deep FIFO) with a beat scoreboard.
module tb_iob_axistream_out_pkt;

    localparam int TDATA_W = 8;
    localparam int LOG2    = 2;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    logic               clk = 1'b0;
    logic               arst_n;
    logic               iob_avalid;
    logic [ADDR_W-1:0]  iob_addr;
    logic [DATA_W-1:0]  iob_wdata;
    logic [3:0]         iob_wstrb;
    logic               iob_rvalid;
    logic [DATA_W-1:0]  iob_rdata;
    logic               iob_ready;
    logic [TDATA_W-1:0] tdata;
    logic               tvalid;
    logic               tready;
    logic               tlast;

    iob_axistream_out_pkt #(
        .TDATA_W(TDATA_W), .FIFO_DEPTH_LOG2(LOG2), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .arst_n(arst_n), .iob_avalid(iob_avalid), .iob_addr(iob_addr),
        .iob_wdata(iob_wdata), .iob_wstrb(iob_wstrb), .iob_rvalid(iob_rvalid),
        .iob_rdata(iob_rdata), .iob_ready(iob_ready), .tdata(tdata), .tvalid(tvalid),
        .tready(tready), .tlast(tlast)
    );

    always #5 clk = ~clk;

    int         compared   = 0;
    int         mismatched = 0;
    logic [8:0] sb [$];
    int         srst_epoch = 0;
    int         exp_pkts   = 0;
    bit         rand_tready = 1'b0;
    bit         pend_last  = 1'b0;
    int         pend_n     = 4;
    logic [31:0] rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_tready) tready = 1'($urandom_range(0, 1));
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        iob_avalid = 1'b1;
        iob_addr   = addr;
        iob_wdata  = data;
        iob_wstrb  = 4'hF;
        tick();
        iob_avalid = 1'b0;
        iob_wstrb  = 4'h0;
    endtask

    task automatic cpu_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data);
        iob_avalid = 1'b1;
        iob_addr   = addr;
        iob_wstrb  = 4'h0;
        tick();
        iob_avalid = 1'b0;
        chk("rvalid", {31'h0, iob_rvalid}, 32'h1);
        data = iob_rdata;
    endtask

    task automatic write_last(input int n);
        cpu_write(5'h04, 32'(n));
        pend_last = 1'b1;
        pend_n    = ((n == 0) || (n > 4)) ? 4 : n;
    endtask

    // Accepted word: queue its expected beats, LSB lane first.
    task automatic write_data(input logic [31:0] w);
        int nb;
        cpu_write(5'h00, w);
        nb = pend_last ? pend_n : 4;
        for (int i = 0; i < nb; i++) begin
            sb.push_back({(pend_last && (i == nb - 1)), w[i*8 +: 8]});
        end
        if (pend_last) exp_pkts++;
        pend_last = 1'b0;
    endtask

    task automatic drain(input string tag);
        rand_tready = 1'b0;
        tready      = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        tick();
        tick();
        chk({tag, "_sb_left"}, 32'(sb.size()), 32'h0);
        chk({tag, "_tvalid_idle"}, {31'h0, tvalid}, 32'h0);
    endtask

    // Stream monitor: checks stall stability and pops the scoreboard on each handshake.
    logic       mon_stall = 1'b0;
    logic [7:0] mon_data;
    logic       mon_last;
    int         mon_epoch = 0;
    logic [8:0] e;
    always @(negedge clk) begin
        if (arst_n) begin
            if (mon_stall && (mon_epoch == srst_epoch)) begin
                chk("hold_tvalid", {31'h0, tvalid}, 32'h1);
                chk("hold_tdata", {24'h0, tdata}, {24'h0, mon_data});
                chk("hold_tlast", {31'h0, tlast}, {31'h0, mon_last});
            end
            mon_epoch = srst_epoch;
            if (tvalid && tready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {24'h0, tdata}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("tdata", {24'h0, tdata}, {24'h0, e[7:0]});
                    chk("tlast", {31'h0, tlast}, {31'h0, e[8]});
                end
            end
            mon_stall = tvalid && !tready;
            mon_data  = tdata;
            mon_last  = tlast;
        end
    end

    initial begin
        arst_n = 1'b0; iob_avalid = 1'b0; iob_addr = '0; iob_wdata = '0; iob_wstrb = 4'h0;
        tready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tvalid", {31'h0, tvalid}, 32'h0);
        chk("rst_tlast", {31'h0, tlast}, 32'h0);
        chk("rst_tdata", {24'h0, tdata}, 32'h0);
        chk("rst_rvalid", {31'h0, iob_rvalid}, 32'h0);
        chk("rst_rdata", iob_rdata, 32'h0);
        chk("ready", {31'h0, iob_ready}, 32'h1);
        @(posedge clk); #1;
        arst_n = 1'b1;
        tick();
        cpu_read(5'h0C, rd); chk("rst_status", rd, 32'h0000_0002);
        cpu_read(5'h08, rd); chk("rst_ctrl", rd, 32'h0000_0001);
        cpu_read(5'h10, rd); chk("rst_pktcnt", rd, 32'h0);
        cpu_read(5'h14, rd); chk("unmapped_rd", rd, 32'h0);

        // T1: full word, latency two cycles, back-to-back beats
        tready = 1'b1;
        write_data(32'h4433_2211);
        chk("t1_lat_t1", {31'h0, tvalid}, 32'h0);
        tick(); chk("t1_lat_t2", {31'h0, tvalid}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t1_b2b", {31'h0, tvalid}, 32'h1);
        end
        tick(); chk("t1_end", {31'h0, tvalid}, 32'h0);
        drain("t1");

        // T2: three-lane last word
        write_last(3);
        write_data(32'hAABB_CCDD);
        drain("t2");
        cpu_read(5'h10, rd); chk("t2_pktcnt", rd, 32'h1);
        cpu_write(5'h10, 32'h0000_1234);
        cpu_read(5'h10, rd); chk("ro_write_ignored", rd, 32'h1);

        // T3: fill, overflow with LAST pending kept, then drain
        tready = 1'b0;
        for (int i = 0; i < 5; i++) write_data(32'h0302_0100 + 32'(i) * 32'h0404_0404);
        cpu_read(5'h0C, rd); chk("t3_full", rd, 32'h0004_0001);
        write_last(1);
        cpu_write(5'h00, 32'hDEAD_BEEF);
        cpu_read(5'h0C, rd); chk("t3_ovf", rd, 32'h0004_0005);
        drain("t3");
        cpu_read(5'h0C, rd); chk("t3_empty_ovf", rd, 32'h0000_0006);
        cpu_write(5'h0C, 32'h0000_0004);
        cpu_read(5'h0C, rd); chk("t3_ovf_w1c", rd, 32'h0000_0002);
        write_data(32'h0000_00EE);
        drain("t3b");

        // T4: random backpressure, packets of varied lengths including clamped N
        rand_tready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            rd = 32'h1;
            for (int p = 0; p < 200; p++) begin
                cpu_read(5'h0C, rd);
                if (!rd[0]) break;
            end
            chk("t4_poll_full", {31'h0, rd[0]}, 32'h0);
            if ($urandom_range(0, 3) == 0) write_last(int'($urandom_range(0, 7)));
            write_data($urandom);
        end
        drain("t4");
        cpu_read(5'h10, rd); chk("t4_pktcnt", rd, 32'(exp_pkts));

        // T5: soft reset with a stalled beat and a pending LAST
        tready = 1'b0;
        write_data(32'h1111_1111);
        write_data(32'h2222_2222);
        write_last(2);
        chk("t5_valid_before", {31'h0, tvalid}, 32'h1);
        cpu_write(5'h08, 32'h0000_0003);
        srst_epoch++;
        sb.delete();
        pend_last = 1'b0;
        chk("t5_tvalid_drop", {31'h0, tvalid}, 32'h0);
        cpu_read(5'h0C, rd); chk("t5_status", rd, 32'h0000_0002);
        cpu_read(5'h08, rd); chk("t5_ctrl", rd, 32'h0000_0001);
        write_data(32'h0BAD_CAFE);
        drain("t5");

        // T6: disable during the second lane; word drains, next word waits
        tready = 1'b0;
        write_data(32'hA3A2_A1A0);
        write_data(32'hB3B2_B1B0);
        chk("t6_valid", {31'h0, tvalid}, 32'h1);
        tready = 1'b1;
        tick();
        tready = 1'b0;
        cpu_write(5'h08, 32'h0000_0000);
        tready = 1'b1;
        repeat (5) tick();
        chk("t6_stopped", {31'h0, tvalid}, 32'h0);
        cpu_read(5'h0C, rd); chk("t6_status", rd, 32'h0001_0000);
        chk("t6_sb_waiting", 32'(sb.size()), 32'h4);
        cpu_write(5'h08, 32'h0000_0001);
        drain("t6");
        cpu_read(5'h10, rd); chk("final_pktcnt", rd, 32'(exp_pkts));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
